// File: rtl/fp32_divider_seq.sv
// ============================================================================
// fp32_divider_seq : iterative IEEE-754 single-precision divider
//                    (restoring, one quotient bit per cycle, valid/ready I/O)
// Revision: 1.0
// ============================================================================
`default_nettype none

module fp32_divider_seq #(
    parameter int ROUND_NEAREST = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        Exception,
    output logic        Overflow,
    output logic        Underflow
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD       = 3'd1,
        S_DIVIDE     = 3'd2,
        S_NORM_ROUND = 3'd3,
        S_DONE       = 3'd4
    } state_t;

    localparam logic [4:0]  C_LAST_ITER = 5'd25;
    localparam logic [31:0] C_QNAN      = 32'h7FC0_0000;
    localparam logic [30:0] C_INF_MAG   = 31'h7F80_0000;

    state_t       r_state;
    logic         r_in_ready;
    logic         r_out_valid;
    logic [31:0]  r_result;
    logic         r_exception;
    logic         r_overflow;
    logic         r_underflow;

    logic         r_sign;
    logic [7:0]   r_ea;
    logic [7:0]   r_eb;
    logic [23:0]  r_ma;
    logic [23:0]  r_mb;
    logic [25:0]  r_rem;
    logic [25:0]  r_q;
    logic [4:0]   r_count;

    logic         w_a_zero;
    logic         w_b_zero;
    logic         w_any_max;
    logic         w_rem_ge;
    logic [25:0]  w_rem_sub;

    logic signed [9:0] w_exp;
    logic signed [9:0] w_e_pre;
    logic signed [9:0] w_e_fin;
    logic [22:0]  w_mant;
    logic         w_guard;
    logic         w_sticky;
    logic         w_round_up;
    logic [23:0]  w_mant_sum;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign Exception = r_exception;
    assign Overflow  = r_overflow;
    assign Underflow = r_underflow;

    // Denormals are treated as zero: only the exponent field decides zero-ness.
    assign w_a_zero  = (r_ea == 8'd0);
    assign w_b_zero  = (r_eb == 8'd0);
    assign w_any_max = (r_ea == 8'hFF) || (r_eb == 8'hFF);

    assign w_rem_ge  = (r_rem >= {2'b00, r_mb});
    assign w_rem_sub = w_rem_ge ? (r_rem - {2'b00, r_mb}) : r_rem;

    assign w_exp = signed'({2'b00, r_ea}) - signed'({2'b00, r_eb});

    always_comb begin
        w_mant   = 23'd0;
        w_guard  = 1'b0;
        w_sticky = 1'b0;
        w_e_pre  = 10'sd0;
        if (r_q[25]) begin
            w_mant   = r_q[24:2];
            w_guard  = r_q[1];
            w_sticky = r_q[0] | (|r_rem);
            w_e_pre  = w_exp + 10'sd127;
        end else begin
            w_mant   = r_q[23:1];
            w_guard  = r_q[0];
            w_sticky = |r_rem;
            w_e_pre  = w_exp + 10'sd126;
        end
    end

    assign w_round_up = (ROUND_NEAREST != 0) && w_guard && (w_sticky || w_mant[0]);
    assign w_mant_sum = {1'b0, w_mant} + {23'd0, w_round_up};
    // A mantissa carry leaves sum[22:0] at zero, so only the exponent moves.
    assign w_e_fin    = w_e_pre + (w_mant_sum[23] ? 10'sd1 : 10'sd0);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= 32'd0;
            r_exception <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_sign      <= 1'b0;
            r_ea        <= 8'd0;
            r_eb        <= 8'd0;
            r_ma        <= 24'd0;
            r_mb        <= 24'd0;
            r_rem       <= 26'd0;
            r_q         <= 26'd0;
            r_count     <= 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sign      <= a_operand[31] ^ b_operand[31];
                        r_ea        <= a_operand[30:23];
                        r_eb        <= b_operand[30:23];
                        r_ma        <= {1'b1, a_operand[22:0]};
                        r_mb        <= {1'b1, b_operand[22:0]};
                        r_exception <= 1'b0;
                        r_overflow  <= 1'b0;
                        r_underflow <= 1'b0;
                        r_in_ready  <= 1'b0;
                        r_state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_rem   <= {2'b00, r_ma};
                    r_q     <= 26'd0;
                    r_count <= 5'd0;
                    if (w_any_max || (w_a_zero && w_b_zero)) begin
                        r_result    <= C_QNAN;
                        r_exception <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (w_b_zero) begin
                        r_result    <= {r_sign, C_INF_MAG};
                        r_exception <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (w_a_zero) begin
                        r_result    <= {r_sign, 31'd0};
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_state <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    r_rem   <= w_rem_sub << 1;
                    r_q     <= {r_q[24:0], w_rem_ge};
                    r_count <= r_count + 5'd1;
                    if (r_count == C_LAST_ITER) begin
                        r_state <= S_NORM_ROUND;
                    end
                end
                S_NORM_ROUND: begin
                    if (w_e_fin >= 10'sd255) begin
                        r_result   <= {r_sign, C_INF_MAG};
                        r_overflow <= 1'b1;
                    end else if (w_e_fin <= 10'sd0) begin
                        r_result    <= {r_sign, 31'd0};
                        r_underflow <= 1'b1;
                    end else begin
                        r_result <= {r_sign, w_e_fin[7:0], w_mant_sum[22:0]};
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp32_divider_seq.sv
// ============================================================================
// tb_fp32_divider_seq : directed self-checking bench for fp32_divider_seq
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fp32_divider_seq;

    logic        CLK;
    logic        RESET;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a_operand;
    logic [31:0] b_operand;

    logic        in_ready,  out_valid,  Exception,  Overflow,  Underflow;
    logic [31:0] result;
    logic        in_ready2, out_valid2, exception2, overflow2, underflow2;
    logic [31:0] result2;

    int total = 0;
    int bad   = 0;

    fp32_divider_seq #(.ROUND_NEAREST(1)) dut (
        .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
        .a_operand(a_operand), .b_operand(b_operand), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .Exception(Exception),
        .Overflow(Overflow), .Underflow(Underflow)
    );

    fp32_divider_seq #(.ROUND_NEAREST(0)) dut_trunc (
        .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready2),
        .a_operand(a_operand), .b_operand(b_operand), .out_valid(out_valid2),
        .out_ready(out_ready), .result(result2), .Exception(exception2),
        .Overflow(overflow2), .Underflow(underflow2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Issue one operation, scramble the inputs after the accept edge, and
    // wait (bounded) for out_valid; the result is left pending for the caller.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] r, output logic [2:0] f);
        @(negedge CLK);
        a_operand = a;
        b_operand = b;
        in_valid  = 1'b1;
        @(posedge CLK);
        #1;
        in_valid  = 1'b0;
        a_operand = 32'h3F80_0000;
        b_operand = 32'h0000_0000;
        lat = 0;
        while (lat < 64) begin
            @(posedge CLK);
            lat++;
            #1;
            if (out_valid) break;
        end
        r = result;
        f = {Exception, Overflow, Underflow};
    endtask

    task automatic accept_result();
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a_operand = 32'd0; b_operand = 32'd0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        total++;
        if (result !== 32'd0 || {Exception, Overflow, Underflow} !== 3'b000) begin
            bad++; $display("FAIL reset_out: result=%h flags=%b want 00000000 000", result, {Exception, Overflow, Underflow});
        end
        RESET = 1'b0;
    endtask

    task automatic test_basic();
        int lat; logic [31:0] r; logic [2:0] f;
        run_op(32'h4120_0000, 32'h4000_0000, lat, r, f);
        total++;
        if (lat !== 28) begin bad++; $display("FAIL basic_latency: got %0d want 28", lat); end
        total++;
        if (r !== 32'h40A0_0000 || f !== 3'b000) begin
            bad++; $display("FAIL basic_10div2: result=%h flags=%b want 40a00000 000", r, f);
        end
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_busy: in_ready=%b want 0", in_ready); end
        accept_result();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL basic_accept: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        run_op(32'hC120_0000, 32'h4000_0000, lat, r, f);
        total++;
        if (r !== 32'hC0A0_0000 || f !== 3'b000) begin
            bad++; $display("FAIL basic_neg: result=%h flags=%b want c0a00000 000", r, f);
        end
        accept_result();
    endtask

    task automatic test_rounding();
        int lat; logic [31:0] r; logic [2:0] f;
        run_op(32'h3F80_0000, 32'h4040_0000, lat, r, f);
        total++;
        if (r !== 32'h3EAA_AAAB || f !== 3'b000) begin
            bad++; $display("FAIL round_nearest: result=%h flags=%b want 3eaaaaab 000", r, f);
        end
        total++;
        if (out_valid2 !== 1'b1 || result2 !== 32'h3EAA_AAAA) begin
            bad++; $display("FAIL round_trunc: valid=%b result=%h want 1 3eaaaaaa", out_valid2, result2);
        end
        accept_result();
    endtask

    task automatic test_special();
        int lat; logic [31:0] r; logic [2:0] f;
        run_op(32'hBF80_0000, 32'h0000_0000, lat, r, f);
        total++;
        if (lat !== 1) begin bad++; $display("FAIL special_latency: got %0d want 1", lat); end
        total++;
        if (r !== 32'hFF80_0000 || f !== 3'b100) begin
            bad++; $display("FAIL special_divzero: result=%h flags=%b want ff800000 100", r, f);
        end
        accept_result();
        run_op(32'h0000_0000, 32'h0000_0000, lat, r, f);
        total++;
        if (r !== 32'h7FC0_0000 || f !== 3'b100) begin
            bad++; $display("FAIL special_zero_zero: result=%h flags=%b want 7fc00000 100", r, f);
        end
        accept_result();
        run_op(32'h7F80_0000, 32'h4000_0000, lat, r, f);
        total++;
        if (r !== 32'h7FC0_0000 || f !== 3'b100) begin
            bad++; $display("FAIL special_inf: result=%h flags=%b want 7fc00000 100", r, f);
        end
        accept_result();
        run_op(32'h8000_0000, 32'h4000_0000, lat, r, f);
        total++;
        if (r !== 32'h8000_0000 || f !== 3'b000 || lat !== 1) begin
            bad++; $display("FAIL special_zero_num: result=%h flags=%b lat=%0d want 80000000 000 1", r, f, lat);
        end
        accept_result();
    endtask

    task automatic test_ovf_unf();
        int lat; logic [31:0] r; logic [2:0] f;
        run_op(32'h7F00_0000, 32'h3F00_0000, lat, r, f);
        total++;
        if (r !== 32'h7F80_0000 || f !== 3'b010) begin
            bad++; $display("FAIL overflow: result=%h flags=%b want 7f800000 010", r, f);
        end
        accept_result();
        run_op(32'h0080_0000, 32'h4000_0000, lat, r, f);
        total++;
        if (r !== 32'h0000_0000 || f !== 3'b001) begin
            bad++; $display("FAIL underflow: result=%h flags=%b want 00000000 001", r, f);
        end
        accept_result();
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] r; logic [2:0] f; int errs;
        run_op(32'h4120_0000, 32'h4000_0000, lat, r, f);
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            a_operand = 32'hBF80_0000;
            b_operand = 32'h0000_0000;
            in_valid  = 1'b1;
            @(posedge CLK);
            #1;
            if (result !== 32'h40A0_0000 || out_valid !== 1'b1 || in_ready !== 1'b0 ||
                {Exception, Overflow, Underflow} !== 3'b000) errs++;
        end
        in_valid = 1'b0;
        total++;
        if (errs !== 0) begin
            bad++; $display("FAIL hold_stable: %0d unstable cycles, last result=%h want 0 and 40a00000", errs, result);
        end
        accept_result();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL hold_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        run_op(32'h40C0_0000, 32'h4040_0000, lat, r, f);
        total++;
        if (r !== 32'h4000_0000 || f !== 3'b000 || lat !== 28) begin
            bad++; $display("FAIL hold_next_op: result=%h flags=%b lat=%0d want 40000000 000 28", r, f, lat);
        end
        accept_result();
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] r; logic [2:0] f; int seen;
        @(negedge CLK);
        a_operand = 32'h4120_0000;
        b_operand = 32'h4000_0000;
        in_valid  = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        repeat (13) @(posedge CLK);
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL midreset_busy: in_ready=%b want 0", in_ready); end
        #2;
        RESET = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 ||
            {Exception, Overflow, Underflow} !== 3'b000) begin
            bad++; $display("FAIL midreset_async: in_ready=%b out_valid=%b result=%h want 1 0 00000000",
                            in_ready, out_valid, result);
        end
        @(negedge CLK);
        RESET = 1'b0;
        seen = 0;
        for (int i = 0; i < 35; i++) begin
            @(posedge CLK);
            #1;
            if (out_valid) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL midreset_no_valid: out_valid seen %0d cycles want 0", seen); end
        run_op(32'h40C0_0000, 32'h4040_0000, lat, r, f);
        total++;
        if (r !== 32'h4000_0000 || f !== 3'b000) begin
            bad++; $display("FAIL midreset_next_op: result=%h flags=%b want 40000000 000", r, f);
        end
        accept_result();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_special();
        test_ovf_unf();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
